// File: rtl/shapool_pkg.sv
// Shared types and default widths for the shapool job loader.
package shapool_pkg;

  localparam int DEF_JOB_BITS    = 352;
  localparam int DEF_NONCE_BITS  = 32;
  localparam int DEF_DAISY_BITS  = 8;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_RUN,
    ST_RESULT
  } state_t;

endpackage

// File: rtl/shapool_sync_edge.sv
// Synchronises an external serial clock plus its data bits into hwclk and flags rising edges.
// Data travels through the same depth as the clock, so dat_o is aligned with edge_o.
module shapool_sync_edge #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             edge_o,
  output logic [WIDTH-1:0] dat_o
);

  logic [STAGES-1:0][WIDTH:0] sync_q;
  logic [STAGES-1:0]          fill_q;
  logic                       prev_q;
  logic                       seen_low_q;
  logic                       sclk_s;

  assign sclk_s = sync_q[STAGES-1][WIDTH];
  assign dat_o  = sync_q[STAGES-1][WIDTH-1:0];

  // A clock already high when reset releases must drop once before any edge counts.
  assign edge_o = sclk_s & ~prev_q & seen_low_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      fill_q     <= '0;
      prev_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], {sclk_i, dat_i}};
      fill_q <= {fill_q[STAGES-2:0], 1'b1};
      prev_q <= sclk_s;
      if (fill_q[STAGES-1] && !sclk_s) begin
        seen_low_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/shapool_job_loader.sv
// Loads a serial job word, hands it to the core pool, and shifts back a found nonce.
// Daisy mode shifts the nonce-start word independently; global edges in ARMED/RUN restart the load.
module shapool_job_loader
  import shapool_pkg::*;
#(
  parameter int JOB_BITS    = DEF_JOB_BITS,
  parameter int NONCE_BITS  = DEF_NONCE_BITS,
  parameter int DAISY_BITS  = DEF_DAISY_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                  hwclk,
  input  logic                  reset_in,
  input  logic                  data_clk,
  input  logic                  data_in,
  output logic                  data_out,
  output logic                  data_out_en,
  input  logic                  daisy_sel,
  input  logic                  daisy_in,
  output logic                  daisy_out,
  output logic [JOB_BITS-1:0]   job_data,
  output logic [DAISY_BITS-1:0] nonce_start,
  output logic                  job_valid,
  input  logic                  job_ready,
  input  logic                  core_done,
  input  logic                  core_success,
  input  logic [NONCE_BITS-1:0] core_nonce,
  output logic                  core_halt,
  output logic                  busy
);

  localparam int CNT_W = $clog2(JOB_BITS + 1);
  localparam int RES_W = $clog2(NONCE_BITS + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RES_W-1:0]        rcnt_q, rcnt_d;
  logic [JOB_BITS-1:0]     job_q, job_d;
  logic [DAISY_BITS-1:0]   ns_q, ns_d;
  logic [NONCE_BITS-1:0]   shf_q, shf_d;
  logic                    halt_q, halt_d;

  logic                    edge_a, edge_b;
  logic                    din_s, sel_s, dsy_s;
  logic                    g_edge, d_edge;
  logic [JOB_BITS-1:0]     job_shift;

  shapool_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync_data (
    .clk    (hwclk),
    .rst_n  (reset_in),
    .sclk_i (data_clk),
    .dat_i  (data_in),
    .edge_o (edge_a),
    .dat_o  (din_s)
  );

  shapool_sync_edge #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_daisy (
    .clk    (hwclk),
    .rst_n  (reset_in),
    .sclk_i (data_clk),
    .dat_i  ({daisy_sel, daisy_in}),
    .edge_o (edge_b),
    .dat_o  ({sel_s, dsy_s})
  );

  assign g_edge    = edge_a & ~sel_s;
  assign d_edge    = edge_b & sel_s;
  assign job_shift = {job_q[JOB_BITS-2:0], din_s};

  always_ff @(posedge hwclk) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      job_q   <= '0;
      ns_q    <= '0;
      shf_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      job_q   <= job_d;
      ns_q    <= ns_d;
      shf_q   <= shf_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    job_d   = job_q;
    ns_d    = ns_q;
    shf_d   = shf_q;
    halt_d  = 1'b0;

    if (d_edge) begin
      ns_d = {ns_q[DAISY_BITS-2:0], dsy_s};
    end

    case (state_q)
      ST_IDLE: begin
        if (g_edge) begin
          job_d   = job_shift;
          cnt_d   = CNT_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (g_edge) begin
          job_d = job_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(JOB_BITS - 1)) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED, ST_RUN: begin
        // A new job on the wire wins over any handshake or result this cycle.
        if (g_edge) begin
          job_d   = job_shift;
          cnt_d   = CNT_W'(1);
          halt_d  = 1'b1;
          state_d = ST_LOAD;
        end else if (state_q == ST_ARMED) begin
          if (job_ready) begin
            state_d = ST_RUN;
          end
        end else if (core_done) begin
          if (core_success) begin
            shf_d   = core_nonce;
            rcnt_d  = '0;
            state_d = ST_RESULT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESULT: begin
        if (g_edge) begin
          shf_d  = {shf_q[NONCE_BITS-2:0], 1'b0};
          rcnt_d = rcnt_q + RES_W'(1);
          if (rcnt_q == RES_W'(NONCE_BITS - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign job_data    = job_q;
  assign nonce_start = ns_q;
  assign daisy_out   = ns_q[DAISY_BITS-1];
  assign job_valid   = (state_q == ST_ARMED);
  assign busy        = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign data_out_en = (state_q == ST_RESULT);
  assign data_out    = data_out_en & shf_q[NONCE_BITS-1];
  assign core_halt   = halt_q;

endmodule

// File: tb/tb_shapool_job_loader.sv
// Directed bench for shapool_job_loader with a queue-based scoreboard for job words and result bits.
module tb_shapool_job_loader;

  localparam int JB = 16;
  localparam int NB = 8;
  localparam int DB = 4;

  logic          hwclk = 1'b0;
  logic          reset_in = 1'b0;
  logic          data_clk = 1'b0;
  logic          data_in = 1'b0;
  logic          data_out, data_out_en;
  logic          daisy_sel = 1'b0;
  logic          daisy_in = 1'b0;
  logic          daisy_out;
  logic [JB-1:0] job_data;
  logic [DB-1:0] nonce_start;
  logic          job_valid;
  logic          job_ready = 1'b0;
  logic          core_done = 1'b0;
  logic          core_success = 1'b0;
  logic [NB-1:0] core_nonce = '0;
  logic          core_halt, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int jv_cnt = 0;
  int halt_cnt = 0;

  logic [JB-1:0] job_q[$];
  logic          bit_q[$];
  logic [DB-1:0] ns_m;

  shapool_job_loader #(
    .JOB_BITS(JB), .NONCE_BITS(NB), .DAISY_BITS(DB), .SYNC_STAGES(2)
  ) dut (
    .hwclk(hwclk), .reset_in(reset_in), .data_clk(data_clk), .data_in(data_in),
    .data_out(data_out), .data_out_en(data_out_en), .daisy_sel(daisy_sel),
    .daisy_in(daisy_in), .daisy_out(daisy_out), .job_data(job_data),
    .nonce_start(nonce_start), .job_valid(job_valid), .job_ready(job_ready),
    .core_done(core_done), .core_success(core_success), .core_nonce(core_nonce),
    .core_halt(core_halt), .busy(busy)
  );

  always #5 hwclk = ~hwclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a job word is consumed whenever the handshake completes.
  always @(negedge hwclk) begin
    if (reset_in) begin
      if (job_valid) jv_cnt++;
      if (core_halt) halt_cnt++;
      if (job_valid && job_ready) begin
        if (job_q.size() == 0) chk("job_unexpected", 32'd1, 32'd0);
        else chk("job_data_hs", 32'(job_data), 32'(job_q.pop_front()));
      end
    end
  end

  task automatic edge_g(input logic d);
    data_in   = d;
    daisy_sel = 1'b0;
    data_clk  = 1'b1;
    repeat (4) @(posedge hwclk);
    #1 data_clk = 1'b0;
    repeat (4) @(posedge hwclk);
    #1;
  endtask

  task automatic edge_d(input logic d);
    daisy_in  = d;
    daisy_sel = 1'b1;
    data_clk  = 1'b1;
    repeat (4) @(posedge hwclk);
    #1 data_clk = 1'b0;
    repeat (4) @(posedge hwclk);
    #1;
  endtask

  task automatic load_bits(input logic [JB-1:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) edge_g(w[i]);
  endtask

  initial begin
    logic [NB-1:0] nv;
    logic [7:0]    dseq;

    // Reset with data_clk held high across release: must not count as an edge.
    data_clk = 1'b1;
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    chk("rst_job_valid", 32'(job_valid), 32'd0);
    chk("rst_data_out_en", 32'(data_out_en), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_daisy_out", 32'(daisy_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_halt", 32'(core_halt), 32'd0);
    chk("rst_job_data", 32'(job_data), 32'd0);
    chk("rst_nonce_start", 32'(nonce_start), 32'd0);
    @(posedge hwclk); #1 reset_in = 1'b1;
    repeat (6) @(posedge hwclk);
    #1 data_clk = 1'b0;
    repeat (6) @(posedge hwclk);
    #1;
    @(negedge hwclk);
    chk("release_busy", 32'(busy), 32'd0);

    // Global load with job_ready held high.
    job_ready = 1'b1;
    jv_cnt = 0;
    job_q.push_back(16'hA5C3);
    load_bits(16'hA5C3, 15, 0);
    @(negedge hwclk);
    chk("load_jv_cycles", 32'(jv_cnt), 32'd1);
    chk("load_busy_run", 32'(busy), 32'd1);
    chk("load_job_data", 32'(job_data), 32'hA5C3);
    chk("load_q_empty", 32'(job_q.size()), 32'd0);

    // Successful result shifted out MSB first.
    nv = 8'h96;
    for (int i = NB - 1; i >= 0; i--) bit_q.push_back(nv[i]);
    @(posedge hwclk); #1 core_nonce = nv; core_done = 1'b1; core_success = 1'b1;
    @(posedge hwclk); #1 core_done = 1'b0; core_success = 1'b0;
    @(negedge hwclk);
    chk("res_en", 32'(data_out_en), 32'd1);
    chk("res_busy", 32'(busy), 32'd0);
    for (int i = 0; i < NB; i++) begin
      @(negedge hwclk);
      chk("res_data_out", 32'(data_out), 32'(bit_q.pop_front()));
      edge_g(1'b0);
    end
    @(negedge hwclk);
    chk("res_en_done", 32'(data_out_en), 32'd0);
    chk("res_out_done", 32'(data_out), 32'd0);

    // core_done outside RUN is ignored.
    @(posedge hwclk); #1 core_done = 1'b1; core_success = 1'b1;
    @(posedge hwclk); #1 core_done = 1'b0; core_success = 1'b0;
    @(negedge hwclk);
    chk("idle_done_en", 32'(data_out_en), 32'd0);

    // Daisy chain shift against a small shift-register model.
    ns_m = '0;
    dseq = 8'b1011_0000;
    for (int i = 7; i >= 0; i--) begin
      @(negedge hwclk);
      chk("daisy_out", 32'(daisy_out), 32'(ns_m[DB-1]));
      edge_d(dseq[i]);
      ns_m = {ns_m[DB-2:0], dseq[i]};
      if (i == 4) chk("daisy_ns_b", 32'(nonce_start), 32'hB);
    end
    chk("daisy_ns_end", 32'(nonce_start), 32'(ns_m));
    chk("daisy_job_kept", 32'(job_data), 32'hA5C3);
    chk("daisy_busy", 32'(busy), 32'd0);

    // ARMED without ready, then restart after 5 edges.
    job_ready = 1'b0;
    load_bits(16'h1234, 15, 0);
    @(negedge hwclk);
    chk("armed_jv", 32'(job_valid), 32'd1);
    chk("armed_busy", 32'(busy), 32'd1);
    chk("armed_job", 32'(job_data), 32'h1234);
    halt_cnt = 0;
    load_bits(16'hBEEF, 15, 11);
    chk("restart_halt_cnt", 32'(halt_cnt), 32'd1);
    chk("restart_jv", 32'(job_valid), 32'd0);
    load_bits(16'hBEEF, 10, 0);
    @(negedge hwclk);
    chk("rearm_jv", 32'(job_valid), 32'd1);
    chk("rearm_job", 32'(job_data), 32'hBEEF);
    job_q.push_back(16'hBEEF);
    @(posedge hwclk); #1 job_ready = 1'b1;
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    chk("rearm_run_busy", 32'(busy), 32'd1);
    chk("rearm_q_empty", 32'(job_q.size()), 32'd0);

    // Data edge and core_done+success in the same RUN cycle: restart wins.
    halt_cnt = 0;
    job_q.push_back(16'h5A5A);
    @(posedge hwclk); #1 data_in = 1'b0; daisy_sel = 1'b0; data_clk = 1'b1;
    @(posedge hwclk);
    @(posedge hwclk); #1 core_done = 1'b1; core_success = 1'b1; core_nonce = 8'hFF;
    @(posedge hwclk); #1 core_done = 1'b0; core_success = 1'b0;
    @(negedge hwclk);
    chk("sim_halt", 32'(core_halt), 32'd1);
    chk("sim_en", 32'(data_out_en), 32'd0);
    chk("sim_busy_load", 32'(busy), 32'd0);
    @(negedge hwclk);
    chk("sim_halt_once", 32'(core_halt), 32'd0);
    @(posedge hwclk); #1 data_clk = 1'b0;
    repeat (4) @(posedge hwclk);
    #1;
    chk("sim_en_hold", 32'(data_out_en), 32'd0);
    load_bits(16'h5A5A, 14, 0);
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    chk("sim_halt_total", 32'(halt_cnt), 32'd1);
    chk("sim_q_empty", 32'(job_q.size()), 32'd0);

    // Reset mid-LOAD at bit 9, then a fresh word.
    load_bits(16'h0F0F, 15, 7);
    @(posedge hwclk); #1 reset_in = 1'b0;
    @(posedge hwclk);
    @(negedge hwclk);
    chk("mid_rst_job", 32'(job_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_jv", 32'(job_valid), 32'd0);
    chk("mid_rst_halt", 32'(core_halt), 32'd0);
    chk("mid_rst_out", 32'({data_out, data_out_en, daisy_out}), 32'd0);
    @(posedge hwclk); #1 reset_in = 1'b1;
    repeat (5) @(posedge hwclk);
    #1;
    jv_cnt = 0;
    job_q.push_back(16'hC0DE);
    load_bits(16'hC0DE, 15, 0);
    repeat (3) @(posedge hwclk);
    @(negedge hwclk);
    chk("fresh_jv_cycles", 32'(jv_cnt), 32'd1);
    chk("fresh_job", 32'(job_data), 32'hC0DE);
    chk("fresh_q_empty", 32'(job_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
